// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single-outstanding imem requests feeding a small FIFO
// toward decode. Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        validF
);

  localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);
  localparam logic [31:0] RESET_PC_C = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        iq_pc_q    [IQ_DEPTH];
  logic [31:0]        iq_instr_q [IQ_DEPTH];

  logic [31:0]        redirect_tgt;
  logic               accept;
  logic               head_vld;
  logic               enq;
  logic               deq;

  assign redirect_tgt = redirect_pc & ~32'h3;
  assign imem_addr    = fetch_pc_q;

  // In FETCH nothing is outstanding, so the occupancy test alone bounds the queue.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
        end else if (count_q < DEPTH_C) begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          state_d = S_FETCH;
          if (redirect) begin
            fetch_pc_d = redirect_tgt;
          end else begin
            accept     = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          state_d    = S_DRAIN;
          fetch_pc_d = redirect_tgt;
        end
      end
      S_DRAIN: begin
        if (redirect) fetch_pc_d = redirect_tgt;
        if (imem_valid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      accept   = 1'b0;
    end
  end

  always_comb begin
    head_vld = (count_q != '0);
    deq      = head_vld && !stallD && !redirect;
`ifdef FETCH_BYPASS_EN
    // An empty queue lets the response go straight to decode; it is kept only if decode stalls.
    enq    = accept && (head_vld || stallD);
    validF = !rst && (head_vld || accept);
    pcF    = head_vld ? iq_pc_q[rd_ptr_q]    : fetch_pc_q;
    instrF = head_vld ? iq_instr_q[rd_ptr_q] : imem_rdata;
`else
    enq    = accept;
    validF = !rst && head_vld;
    pcF    = iq_pc_q[rd_ptr_q];
    instrF = iq_instr_q[rd_ptr_q];
`endif
    if (!validF) begin
      pcF    = '0;
      instrF = '0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC_C;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage carries no reset; the occupancy counter alone defines validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      iq_pc_q[wr_ptr_q]    <= fetch_pc_q;
      iq_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch stream and request addresses are
// queued by the stimulus; monitors pop and compare on every consume / request.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stallD = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        validF;

  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_valid2 = 1'b0;
  logic [31:0] imem_rdata2 = '0;
  logic        stallD2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic [31:0] pcF2;
  logic [31:0] instrF2;
  logic        validF2;

  fent_t       exp_f[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_a2[$];
  int          checks = 0;
  int          passes = 0;
  int          req_cnt = 0;

  int          lat = 1;
  logic        pend = 1'b0;
  int          cd = 0;
  logic [31:0] paddr = '0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .IQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stallD(stallD),
    .redirect(redirect), .redirect_pc(redirect_pc), .pcF(pcF),
    .instrF(instrF), .validF(validF)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .IQ_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid2), .imem_rdata(imem_rdata2), .stallD(stallD2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .pcF(pcF2),
    .instrF(instrF2), .validF(validF2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1357};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic exp_fetch(logic [31:0] pc);
    fent_t e;
    e.pc = pc;
    e.instr = instr_of(pc);
    exp_f.push_back(e);
  endtask

  // Memory for the main instance: in-order, one outstanding, latency = lat cycles.
  always @(posedge clk) begin
    imem_valid <= 1'b0;
    if (pend) begin
      if (cd <= 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= instr_of(paddr);
        pend       <= 1'b0;
      end else begin
        cd <= cd - 1;
      end
    end
    if (imem_req) begin
      if (lat <= 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= instr_of(imem_addr);
        pend       <= 1'b0;
      end else begin
        pend  <= 1'b1;
        cd    <= lat - 1;
        paddr <= imem_addr;
      end
    end
  end

  always @(posedge clk) begin
    imem_valid2 <= imem_req2;
    imem_rdata2 <= instr_of(imem_addr2);
  end

  // Fetch-stream monitor: every consumed head must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && validF && !stallD && !redirect) begin
      if (exp_f.size() == 0) begin
        checks++;
        $display("FAIL unexpected_consume: got pc %h, required no valid entry", pcF);
      end else begin
        fent_t e;
        e = exp_f.pop_front();
        chk("fetch_pc", pcF, e.pc);
        chk("fetch_instr", instrF, e.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && imem_req) begin
      req_cnt++;
      if (exp_a.size() != 0) chk("imem_addr", imem_addr, exp_a.pop_front());
    end
    if (!rst && imem_req2 && exp_a2.size() != 0) chk("wrap_imem_addr", imem_addr2, exp_a2.pop_front());
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    redirect = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic finish_test(string name, int budget);
    int n;
    n = 0;
    while ((exp_f.size() != 0 || exp_a.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_f.size() == 0 && exp_a.size() == 0) passes++;
    else $display("FAIL %s_drain: got %0d fetch and %0d addr entries left, required 0",
                  name, exp_f.size(), exp_a.size());
    @(posedge clk);
    #1 stallD = 1'b1;
    exp_f.delete();
    exp_a.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    exp_a2.push_back(32'hFFFF_FFF8);
    exp_a2.push_back(32'hFFFF_FFFC);
    exp_a2.push_back(32'h0000_0000);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_validF", {31'd0, validF}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pcF", pcF, 32'd0);
    chk("rst_instrF", instrF, 32'd0);

    // Streaming fetch, latency 1
    stallD = 1'b0;
    do_reset();
    lat = 1;
    exp_a.push_back(32'h0);
    exp_a.push_back(32'h4);
    exp_a.push_back(32'h8);
    exp_fetch(32'h0);
    exp_fetch(32'h4);
    exp_fetch(32'h8);
    exp_fetch(32'hC);
    @(negedge clk);
    chk("first_req_after_rst", {31'd0, imem_req}, 32'd1);
    finish_test("stream", 40);

    // Decode stall fills the queue and holds the head
    do_reset();
    lat = 1;
    req_cnt = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_head_pc_early", pcF, 32'h0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("stall_req_count", req_cnt, 32'd2);
    chk("stall_req_low", {31'd0, imem_req}, 32'd0);
    chk("stall_validF", {31'd0, validF}, 32'd1);
    chk("stall_head_pc_late", pcF, 32'h0);
    exp_fetch(32'h0);
    exp_fetch(32'h4);
    exp_fetch(32'h8);
    @(posedge clk);
    #1 stallD = 1'b0;
    finish_test("stall", 40);

    // Redirect while waiting, latency 3: stale response is drained
    do_reset();
    lat = 3;
    stallD = 1'b0;
    exp_a.push_back(32'h0);
    exp_a.push_back(32'h100);
    exp_a.push_back(32'h104);
    exp_fetch(32'h100);
    exp_fetch(32'h104);
    @(posedge clk);
    #1 redirect = 1'b1;
    redirect_pc = 32'h103;
    @(posedge clk);
    #1 redirect = 1'b0;
    finish_test("redirect_wait", 60);

    // Redirect coincident with a response and a consume
    do_reset();
    lat = 1;
    exp_a.push_back(32'h0);
    exp_a.push_back(32'h4);
    exp_a.push_back(32'h200);
    exp_a.push_back(32'h204);
    exp_fetch(32'h200);
    exp_fetch(32'h204);
    repeat (3) @(posedge clk);
    #1 stallD = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    chk("coincide_head_valid", {31'd0, validF}, 32'd1);
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    chk("flush_validF", {31'd0, validF}, 32'd0);
    chk("flush_pcF", pcF, 32'h0);
    finish_test("redirect_coincide", 40);

    // Reset mid-WAIT with a late response
    do_reset();
    lat = 4;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midwait_rst_validF", {31'd0, validF}, 32'd0);
    chk("midwait_rst_req", {31'd0, imem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("late_resp_validF", {31'd0, validF}, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    exp_fetch(32'h0);
    exp_fetch(32'h4);
    @(posedge clk);
    #1 stallD = 1'b0;
    @(negedge clk);
    chk("late_resp_ignored", {31'd0, validF}, 32'd0);
    finish_test("rst_midwait", 60);

    checks++;
    if (exp_a2.size() == 0) passes++;
    else $display("FAIL wrap_drain: got %0d addresses left, required 0", exp_a2.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
